alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on posedge.
REQ-002 SHALL have ports: res  in  1  reset, asynchronous, active-high.
REQ-003 req_valid in 1, req_ready out 1, req_op in 3, req_wide in 1, req_a in 16, req_b in 16: command channel (only [7:0] used when req_wide=0).
REQ-004 rsp_valid out 1, rsp_ready in 1, rsp_data out 16, rsp_ov out 1, rsp_eq out 1, rsp_err out 1: response channel.
REQ-005 ALU side: alu0w out 1, alu0d out 8, alu1w out 1, alu1d out 8, alu_out_i in 8, alu_flag_ov_i in 1, alu_flag_eq_i in 1.
REQ-006 ALU strobes, out 1 each: alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or, alu_not, alu_cmp, alu_hlt, alu_flag_res.
REQ-007 req_op encoding: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 cmp, 6 hlt, 7 illegal.

Function
REQ-008 States: IDLE, FRES, LOAD, EXEC, DONE, HALTED; all ALU-side outputs SHALL be decoded from the state register only (Moore), zero outside listed states.
REQ-009 req_ready SHALL be 1 only in IDLE; command accepted on posedge with req_valid&&req_ready; req_op/req_wide/req_a/req_b captured then.
REQ-010 FRES: alu_flag_res=1 for exactly one cycle; entered after every accepted legal non-hlt command.
REQ-011 LOAD: alu0w=alu1w=1 for one cycle; alu0d/alu1d = current byte of a/b (pass 0 low byte, pass 1 high byte).
REQ-012 EXEC: exactly one op strobe high for one cycle; alu_out_i, alu_flag_ov_i, alu_flag_eq_i sampled at the posedge ending EXEC (ALU updates on the mid-cycle negedge).
REQ-013 Pass 0 strobes: add->alu_add, sub->alu_sub, and/or/not/cmp->matching strobe; pass 1 (wide only): add->alu_add_ov, sub->alu_sub_ov, others same as pass 0.
REQ-014 Narrow: FRES, LOAD, EXEC, DONE; wide: FRES, LOAD, EXEC, LOAD, EXEC, DONE (no FRES between passes; carry preserved).
REQ-015 rsp_data: narrow {8'h00, pass-0 result}; wide {pass-1 result, pass-0 result}; cmp leaves rsp_data=0.
REQ-016 rsp_eq: narrow = pass-0 eq sample; wide = AND of both pass eq samples; 0 for non-cmp ops.
REQ-017 rsp_ov = alu_flag_ov_i sampled at final EXEC (sticky ALU flag, not recomputed).
REQ-018 DONE: rsp_valid=1, outputs stable until posedge with rsp_ready=1, then IDLE; rsp_ready ignored outside DONE.
REQ-019 hlt: accept -> EXEC with alu_hlt=1 one cycle (no FRES/LOAD) -> DONE with rsp_data=0 -> HALTED after handshake; HALTED keeps req_ready=0 until res.
REQ-020 illegal op: no ALU strobe; go directly to DONE with rsp_err=1, rsp_data=0, rsp_ov=0, rsp_eq=0.
REQ-021 Latency, narrow legal op accepted at posedge T: rsp_valid high from posedge T+4; wide: from T+6.
REQ-022 Operand bytes and pass counter SHALL not change between accept and DONE; req_* changes after accept have no effect.

Reset
REQ-023 res=1 SHALL immediately (asynchronously) force IDLE, pass counter 0, captured results 0, all ALU strobes/write enables 0, rsp_valid=0, rsp_err=0, rsp_data=0.
REQ-024 Reset mid-operation (any state incl. HALTED) SHALL abandon the command without a response; req_ready=1 on first cycle after res deasserts.
REQ-025 Sequencer SHALL not assert alu_flag_res on reset; ALU flags are cleared only by the next FRES.

Verification
REQ-026 narrow add a=0x0012 b=0x0034, rsp_ready=1 -> one alu_flag_res, one alu0w/alu1w (0x12/0x34), one alu_add; rsp_data=0x0046, rsp_ov=0, rsp_valid at T+4.
REQ-027 wide add a=0x1234 b=0x0101 -> alu_add then alu_add_ov, bytes 0x34/0x01 then 0x12/0x01; rsp_data=0x1335, rsp_ov=0, rsp_valid at T+6.
REQ-028 wide add a=0xFFFF b=0x0001 -> rsp_data=0x0000, rsp_ov=1; wide cmp a=b=0xA55A -> rsp_eq=1; a=0xA55A b=0xA55B -> rsp_eq=0.
REQ-029 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid and rsp_data held constant, req_ready=0, no ALU strobes; handshake -> IDLE next cycle.
REQ-030 op=7 -> rsp_err=1 at T+1 response, zero ALU strobes; op=6 -> single alu_hlt, then req_ready stays 0 for 20 cycles until res.
REQ-031 res pulsed during second EXEC of wide add -> all strobes drop same cycle, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Drives an external 8-bit ALU through reset, load and execute phases so it can
// serve 8-bit and 16-bit commands, and returns the result on a valid/ready channel.
module alu_sequencer (
  input  logic        clk,
  input  logic        res,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_ov,
  output logic        rsp_eq,
  output logic        rsp_err,
  output logic        alu0w,
  output logic [7:0]  alu0d,
  output logic        alu1w,
  output logic [7:0]  alu1d,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_flag_ov_i,
  input  logic        alu_flag_eq_i,
  output logic        alu_add,
  output logic        alu_add_ov,
  output logic        alu_sub,
  output logic        alu_sub_ov,
  output logic        alu_and,
  output logic        alu_or,
  output logic        alu_not,
  output logic        alu_cmp,
  output logic        alu_hlt,
  output logic        alu_flag_res
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;
  localparam logic [2:0] OP_HLT = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FRES, S_LOAD, S_EXEC, S_DONE, S_HALTED
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic        wide_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        pass_q;
  logic [7:0]  res0_q;
  logic        eq0_q;
  logic [7:0]  strb_q;

  // Strobe vector order: {add, add_ov, sub, sub_ov, and, or, not, cmp}.
  // The high pass of add/sub uses the carry-in variant so the ALU chains bytes.
  function automatic logic [7:0] op_strobes(input logic [2:0] op, input logic pass);
    logic [7:0] s;
    s = '0;
    case (op)
      OP_ADD:  if (pass) s[6] = 1'b1; else s[7] = 1'b1;
      OP_SUB:  if (pass) s[4] = 1'b1; else s[5] = 1'b1;
      OP_AND:  s[3] = 1'b1;
      OP_OR:   s[2] = 1'b1;
      OP_NOT:  s[1] = 1'b1;
      OP_CMP:  s[0] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign {alu_add, alu_add_ov, alu_sub, alu_sub_ov,
          alu_and, alu_or, alu_not, alu_cmp} = strb_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state        <= S_IDLE;
      op_q         <= '0;
      wide_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      pass_q       <= 1'b0;
      res0_q       <= '0;
      eq0_q        <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_ov       <= 1'b0;
      rsp_eq       <= 1'b0;
      rsp_err      <= 1'b0;
      strb_q       <= '0;
      alu_hlt      <= 1'b0;
      alu_flag_res <= 1'b0;
      alu0w        <= 1'b0;
      alu1w        <= 1'b0;
      alu0d        <= '0;
      alu1d        <= '0;
    end else begin
      // ALU-side outputs are one-cycle pulses set only on entry to their state
      strb_q       <= '0;
      alu_hlt      <= 1'b0;
      alu_flag_res <= 1'b0;
      alu0w        <= 1'b0;
      alu1w        <= 1'b0;
      alu0d        <= '0;
      alu1d        <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            wide_q    <= req_wide;
            a_q       <= req_a;
            b_q       <= req_b;
            pass_q    <= 1'b0;
            res0_q    <= '0;
            eq0_q     <= 1'b0;
            req_ready <= 1'b0;
            if (req_op == OP_ILL) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_ov    <= 1'b0;
              rsp_eq    <= 1'b0;
            end else if (req_op == OP_HLT) begin
              state   <= S_EXEC;
              alu_hlt <= 1'b1;
            end else begin
              state        <= S_FRES;
              alu_flag_res <= 1'b1;
            end
          end
        end
        S_FRES: begin
          state <= S_LOAD;
          alu0w <= 1'b1;
          alu1w <= 1'b1;
          alu0d <= a_q[7:0];
          alu1d <= b_q[7:0];
        end
        S_LOAD: begin
          state  <= S_EXEC;
          strb_q <= op_strobes(op_q, pass_q);
        end
        S_EXEC: begin
          if (op_q == OP_HLT) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_ov    <= alu_flag_ov_i;
            rsp_eq    <= 1'b0;
            rsp_err   <= 1'b0;
          end else if (wide_q && !pass_q) begin
            // Second pass goes straight to LOAD so the ALU carry survives
            res0_q <= alu_out_i;
            eq0_q  <= alu_flag_eq_i;
            pass_q <= 1'b1;
            state  <= S_LOAD;
            alu0w  <= 1'b1;
            alu1w  <= 1'b1;
            alu0d  <= a_q[15:8];
            alu1d  <= b_q[15:8];
          end else begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_ov    <= alu_flag_ov_i;
            if (op_q == OP_CMP) begin
              rsp_data <= '0;
              rsp_eq   <= wide_q ? (eq0_q & alu_flag_eq_i) : alu_flag_eq_i;
            end else begin
              rsp_data <= wide_q ? {alu_out_i, res0_q} : {8'h00, alu_out_i};
              rsp_eq   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (op_q == OP_HLT) begin
              state <= S_HALTED;
            end else begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
            end
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
